// File: rtl/mode_nav_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mode_nav_ctrl_pkg                                           |
// | Purpose  : Shared constants and helpers for the front-panel mode       |
// |            navigator: special/first mode values, nav FSM state         |
// |            encoding, button indices and mode wrap arithmetic.          |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package mode_nav_ctrl_pkg;

   localparam int c_MODE_SPECIAL = 0;
   localparam int c_MODE_FIRST   = 1;

   // Navigator FSM state encoding
   localparam logic [0:0] c_ST_NAV     = 1'b0;
   localparam logic [0:0] c_ST_SPECIAL = 1'b1;

   // Button vector indices
   localparam int c_BTN_L   = 0;
   localparam int c_BTN_R   = 1;
   localparam int c_BTN_M   = 2;
   localparam int c_NUM_BTN = 3;

   // Step up with wrap from the last navigable mode back to the first
   function automatic int mode_inc(input int m, input int num_modes);
      return (m >= num_modes) ? c_MODE_FIRST : m + 1;
   endfunction

   // Step down with wrap from the first navigable mode to the last
   function automatic int mode_dec(input int m, input int num_modes);
      return (m <= c_MODE_FIRST) ? num_modes : m - 1;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mode_nav_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mode_nav_ctrl_if                                            |
// | Purpose  : Bundle between board buttons / set flag and the navigator's |
// |            mode outputs.                                               |
// | Ports    : button_l/r/m - raw active-high buttons (asynchronous)       |
// |            set         - time-setting active, freezes L/R navigation   |
// |            mode        - current mode (0 = special)                    |
// |            mode_chg    - one-cycle pulse when mode changes value       |
// |            master = button/set source, slave = navigator               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface mode_nav_ctrl_if #(
   parameter int MODE_W = 4
);
   logic              button_l;
   logic              button_r;
   logic              button_m;
   logic              set;
   logic [MODE_W-1:0] mode;
   logic              mode_chg;

   modport master (
      output button_l, button_r, button_m, set,
      input  mode, mode_chg
   );

   modport slave (
      input  button_l, button_r, button_m, set,
      output mode, mode_chg
   );
endinterface
`default_nettype wire

// File: rtl/mode_nav_ctrl_btn_debounce.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mode_nav_ctrl_btn_debounce                                  |
// | Purpose  : Synchronise one asynchronous button and accept a new level  |
// |            only after it has differed from the accepted level for      |
// |            DEBOUNCE_CYC consecutive cycles.                            |
// | Ports    : clk, rst_n - clock, asynchronous active-low reset           |
// |            i_raw      - raw button level                               |
// |            o_level    - debounced level                                |
// |            o_rise     - one-cycle pulse, first cycle o_level is high   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mode_nav_ctrl_btn_debounce #(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 2_500_000
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_raw,
   output logic      o_level,
   output logic      o_rise
);
   localparam int c_CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [c_CNT_W-1:0]     r_cnt;
   logic                   r_level;
   logic                   r_rise;
   logic                   w_sync;
   logic                   w_done;

   assign w_sync = r_sync[SYNC_STAGES-1];
   // Last cycle of a full stable-and-different window: accept the new level
   assign w_done = (w_sync != r_level) && (r_cnt == c_CNT_W'(DEBOUNCE_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
         r_rise <= w_done & w_sync;
         if (w_sync == r_level) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_level <= w_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
endmodule
`default_nettype wire

// File: rtl/mode_nav_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mode_nav_ctrl                                               |
// | Purpose  : Front-panel mode navigator. Debounces L/R/M buttons, steps  |
// |            mode through 1..NUM_MODES with wrap and hold auto-repeat,   |
// |            and toggles special mode 0 on a long middle press,          |
// |            restoring the previous mode on exit.                        |
// | Ports    : clk, rst_n - clock, asynchronous active-low reset           |
// |            bus        - slave side of mode_nav_ctrl_if                 |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mode_nav_ctrl
   import mode_nav_ctrl_pkg::*;
#(
   parameter int NUM_MODES    = 7,
   parameter int MODE_W       = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 2_500_000,
   parameter int LONG_CYC     = 100_000_000,
   parameter int REPEAT_DLY   = 50_000_000,
   parameter int REPEAT_CYC   = 25_000_000
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   mode_nav_ctrl_if.slave bus
);
   localparam int c_REP_MAX = max2(REPEAT_DLY, REPEAT_CYC);
   localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
   localparam int c_LONG_W  = $clog2(LONG_CYC + 1);

   logic [c_NUM_BTN-1:0] w_raw;
   logic [c_NUM_BTN-1:0] w_lvl;
   logic [c_NUM_BTN-1:0] w_rise;

   assign w_raw = {bus.button_m, bus.button_r, bus.button_l};

   generate
      for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
         mode_nav_ctrl_btn_debounce #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
         ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (w_raw[gi]),
            .o_level (w_lvl[gi]),
            .o_rise  (w_rise[gi])
         );
      end
   endgenerate

   logic w_lvl_l, w_lvl_r, w_lvl_m;
   logic w_rise_l, w_rise_r, w_rise_m;
   assign w_lvl_l  = w_lvl[c_BTN_L];
   assign w_lvl_r  = w_lvl[c_BTN_R];
   assign w_lvl_m  = w_lvl[c_BTN_M];
   assign w_rise_l = w_rise[c_BTN_L];
   assign w_rise_r = w_rise[c_BTN_R];
   assign w_rise_m = w_rise[c_BTN_M];

   // ---------------- L/R hold / auto-repeat ----------------
   // r_rep_cnt holds the number of cycles since the single-button hold began
   // (phase 0) or since the last repeat step (phase 1).
   logic [c_REP_W-1:0] r_rep_cnt;
   logic               r_rep_phase;
   logic               w_single;
   logic               w_rise_lr;
   logic               w_rep_fire;

   assign w_single   = w_lvl_l ^ w_lvl_r;
   assign w_rise_lr  = w_rise_l | w_rise_r;
   assign w_rep_fire = w_single & ~w_rise_lr &
                       (r_rep_phase ? (r_rep_cnt == c_REP_W'(REPEAT_CYC))
                                    : (r_rep_cnt == c_REP_W'(REPEAT_DLY)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b0;
      end else if (!w_single) begin
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b0;
      end else if (w_rise_lr) begin
         // Fresh press (also covers an L<->R hand-over in one cycle)
         r_rep_cnt   <= c_REP_W'(1);
         r_rep_phase <= 1'b0;
      end else if (w_rep_fire) begin
         r_rep_cnt   <= c_REP_W'(1);
         r_rep_phase <= 1'b1;
      end else if (r_rep_cnt != c_REP_W'(c_REP_MAX)) begin
         r_rep_cnt <= r_rep_cnt + c_REP_W'(1);
      end
   end

   // ---------------- Middle long-press ----------------
   // Saturates at LONG_CYC so the toggle fires exactly once per press.
   logic [c_LONG_W-1:0] r_long_cnt;
   logic                w_long_fire;

   assign w_long_fire = w_lvl_m & (r_long_cnt == c_LONG_W'(LONG_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_long_cnt <= '0;
      end else if (!w_lvl_m) begin
         r_long_cnt <= '0;
      end else if (w_rise_m) begin
         r_long_cnt <= c_LONG_W'(1);
      end else if (r_long_cnt != c_LONG_W'(LONG_CYC)) begin
         r_long_cnt <= r_long_cnt + c_LONG_W'(1);
      end
   end

   // A press only steps when the opposite button is not held
   logic w_step_up, w_step_dn;
   assign w_step_up = ~bus.set & ((w_rise_r & ~w_lvl_l) | (w_rep_fire & w_lvl_r));
   assign w_step_dn = ~bus.set & ((w_rise_l & ~w_lvl_r) | (w_rep_fire & w_lvl_l));

   // ---------------- Navigator FSM ----------------
   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [MODE_W-1:0] r_mode;
   logic [MODE_W-1:0] r_saved;
   logic              r_mode_chg;
   logic [MODE_W-1:0] w_mode_nxt;
   logic              w_save;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_ST_NAV;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_NAV:     if (w_long_fire) w_state_nxt = c_ST_SPECIAL;
         c_ST_SPECIAL: if (w_long_fire) w_state_nxt = c_ST_NAV;
         default:      w_state_nxt = c_ST_NAV;
      endcase
   end

   // Long-press has priority over any L/R step in the same cycle
   always_comb begin
      w_mode_nxt = r_mode;
      w_save     = 1'b0;
      case (r_state)
         c_ST_NAV: begin
            if (w_long_fire) begin
               w_mode_nxt = MODE_W'(c_MODE_SPECIAL);
               w_save     = 1'b1;
            end else if (w_step_up) begin
               w_mode_nxt = MODE_W'(mode_inc(int'(r_mode), NUM_MODES));
            end else if (w_step_dn) begin
               w_mode_nxt = MODE_W'(mode_dec(int'(r_mode), NUM_MODES));
            end
         end
         c_ST_SPECIAL: begin
            if (w_long_fire) w_mode_nxt = r_saved;
         end
         default: w_mode_nxt = r_mode;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode     <= MODE_W'(c_MODE_FIRST);
         r_saved    <= MODE_W'(c_MODE_FIRST);
         r_mode_chg <= 1'b0;
      end else begin
         r_mode     <= w_mode_nxt;
         r_mode_chg <= (w_mode_nxt != r_mode);
         if (w_save) r_saved <= r_mode;
      end
   end

   assign bus.mode     = r_mode;
   assign bus.mode_chg = r_mode_chg;
endmodule
`default_nettype wire
